fifo: RTL and testbench

Single-clock synchronous first-in/first-out buffer with parameterised depth and data width. It decouples a producer and a consumer in the same clock domain and provides registered read data plus `empty` and `full` status flags. Writes into a full buffer and reads from an empty buffer are silently ignored, so neither can corrupt stored data.

---
 rtl/fifo.sv | 37 +++
 tb/tb_fifo.sv | 101 ++++++++++
 2 files changed

// File: rtl/fifo.sv
// fifo: single-clock FIFO; write_en/data_in push, read_en pops into registered data_out, empty/full flags, async active-low reset
module fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_SIZE   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_SIZE-1:0] wptr, rptr;
  logic wr, rd;
  assign empty = wptr == rptr;
  assign full  = (wptr[PTR_SIZE-1] != rptr[PTR_SIZE-1]) && (wptr[PTR_SIZE-2:0] == rptr[PTR_SIZE-2:0]);
  assign wr = write_en && !full;
  assign rd = read_en && !empty;
  always_ff @(posedge clk)
    if (wr) mem[wptr[PTR_SIZE-2:0]] <= data_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      data_out <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) begin
        rptr     <= rptr + 1'b1;
        data_out <= mem[rptr[PTR_SIZE-2:0]];
      end
    end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: table-driven and directed checks of fifo ordering, flags, wrap and reset
module tb_fifo;
  logic clk = 0, reset = 0, write_en = 0, read_en = 0;
  logic [7:0] data_in = 0, data_out;
  logic empty, full;
  int compared = 0, mismatched = 0;
  typedef struct {
    logic we, re;
    logic [7:0] din, dout;
    logic emp, ful;
  } vec_t;
  vec_t v[$];
  fifo #(.DEPTH(16), .DATA_WIDTH(8), .PTR_SIZE(5)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .data_out(data_out), .empty(empty), .full(full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask
  task automatic add(input logic we, input logic re, input logic [7:0] din, input logic [7:0] dout, input logic emp, input logic ful);
    vec_t t;
    t.we = we; t.re = re; t.din = din; t.dout = dout; t.emp = emp; t.ful = ful;
    v.push_back(t);
  endtask
  task automatic step(input logic we, input logic re, input logic [7:0] din);
    write_en = we; read_en = re; data_in = din;
    @(posedge clk); #1;
    write_en = 0; read_en = 0;
  endtask
  task automatic flags(input string nm, input logic [7:0] dout, input logic emp, input logic ful);
    chk({nm, " dout"}, data_out, dout);
    chk({nm, " empty"}, {7'd0, empty}, {7'd0, emp});
    chk({nm, " full"}, {7'd0, full}, {7'd0, ful});
  endtask
  task automatic do_reset();
    @(negedge clk); reset = 0; #1;
    @(negedge clk); reset = 1;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) add(1, 0, 8'(i), 8'h00, 0, i == 15);
    add(1, 0, 8'hFF, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) add(0, 1, 8'h00, 8'(i), i == 15, 0);
    add(0, 1, 8'h00, 8'h0F, 1, 0);
    for (int i = 0; i < 10; i++) add(1, 1, 8'(i), i == 0 ? 8'h0F : 8'(i - 1), 0, 0);
    add(0, 1, 8'h00, 8'h09, 1, 0);
    @(negedge clk); #1;
    flags("reset held", 8'h00, 1, 0);
    reset = 1;
    @(posedge clk); #1;
    flags("reset released", 8'h00, 1, 0);
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].we, v[i].re, v[i].din);
      flags($sformatf("vec%0d", i), v[i].dout, v[i].emp, v[i].ful);
    end
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    @(negedge clk); reset = 0; #1;
    flags("async reset", 8'h00, 1, 0);
    @(negedge clk); reset = 1;
    step(0, 1, 8'h00);
    flags("read after reset", 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h10 + i));
    flags("full 10..1F", 8'h00, 0, 1);
    step(1, 1, 8'hAA);
    flags("simul at full", 8'h10, 0, 0);
    for (int i = 1; i < 16; i++) begin
      step(0, 1, 8'h00);
      chk($sformatf("drain1 %0d", i), data_out, 8'(8'h10 + i));
    end
    flags("after drain1", 8'h1F, 1, 0);
    step(0, 1, 8'h00);
    flags("no AA", 8'h1F, 1, 0);
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) step(0, 1, 8'h00);
    flags("pre-wrap", 8'h49, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h80 + i));
    flags("wrap full", 8'h49, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'h00);
      chk($sformatf("wrap rd %0d", i), data_out, 8'(8'h80 + i));
    end
    flags("wrap drained", 8'h8F, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'hC0 + i));
    flags("8 written", 8'h8F, 0, 0);
    do_reset();
    flags("mid reset", 8'h00, 1, 0);
    step(0, 1, 8'h00);
    flags("no stale", 8'h00, 1, 0);
    step(1, 0, 8'h55);
    step(0, 1, 8'h00);
    flags("post reset rw", 8'h55, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
